// File: rtl/uart_pkg.sv
// Shared UART types: receiver state encoding, parity modes and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int PAR_NONE      = 0;
    localparam int PAR_EVEN      = 1;
    localparam int PAR_ODD       = 2;
    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit for a word; narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; flops reset to 1 (idle level).
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic sysclk,
    input  logic nrst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) sync_q <= '1;
        else       sync_q <= {sync_q[STAGES-2:0], din};
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop framing on the sysclk domain,
// timed by ticks recovered from the baud generator's divided clock.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 sysclk_in,
    input  logic                 nrst_in,
    input  logic                 divclk_in,
    input  logic                 rx_serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_done_out,
    output logic                 rx_busy_out,
    output logic                 rx_frame_err_out,
    output logic                 rx_parity_err_out
);

    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING/2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rxs, rxs_d;
    logic                 divs, divs_d;
    logic                 tick;
    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 sample_data, sample_par, sample_stop;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_rx (
        .sysclk (sysclk_in),
        .nrst   (nrst_in),
        .din    (rx_serial_in),
        .dout   (rxs)
    );

    bit_synchronizer #(.STAGES(2)) u_sync_div (
        .sysclk (sysclk_in),
        .nrst   (nrst_in),
        .din    (divclk_in),
        .dout   (divs)
    );

    assign tick        = divs & ~divs_d;
    assign rx_busy_out = (state != IDLE);

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        sample_data  = 1'b0;
        sample_par   = 1'b0;
        sample_stop  = 1'b0;
        case (state)
            IDLE: if (rxs_d && !rxs) state_nxt = START;
            START: if (tick) begin
                if (tick_cnt == TICK_MID) state_nxt = rxs ? IDLE : DATA;
                else                      tick_cnt_nxt = tick_cnt + 1'b1;
            end
            DATA: if (tick) begin
                if (tick_cnt == TICK_LAST) begin
                    sample_data  = 1'b1;
                    tick_cnt_nxt = '0;
                    if (bit_cnt == BIT_LAST) state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    else                     bit_cnt_nxt = bit_cnt + 1'b1;
                end else begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end
            end
            PARITY: if (tick) begin
                if (tick_cnt == TICK_LAST) begin
                    sample_par = 1'b1;
                    state_nxt  = STOP;
                end else begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end
            end
            STOP: if (tick) begin
                // Leaving at mid-stop lets IDLE see a start edge that follows immediately.
                if (tick_cnt == TICK_LAST) begin
                    sample_stop = 1'b1;
                    state_nxt   = rxs ? IDLE : BREAK;
                end else begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end
            end
            BREAK: if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) begin
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            rxs_d             <= 1'b1;
            divs_d            <= 1'b1;
            shreg             <= '0;
            par_err           <= 1'b0;
            rx_data_out       <= '0;
            rx_done_out       <= 1'b0;
            rx_frame_err_out  <= 1'b0;
            rx_parity_err_out <= 1'b0;
        end else begin
            rxs_d       <= rxs;
            divs_d      <= divs;
            rx_done_out <= sample_stop;
            if (sample_data) shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (sample_par)  par_err <= rxs ^ parity_bit(MAX_DATA_BITS'(shreg), PARITY_MODE);
            if (sample_stop) begin
                rx_data_out       <= shreg;
                rx_frame_err_out  <= ~rxs;
                rx_parity_err_out <= par_err;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver and the downstream partner of uart_tx. It consumes the serial line that uart_tx drives and recovers DATA_BITS-wide words, LSB first. Timing comes from the oversampling tick of the shared baud_generator (divclk_out); all logic runs on the single system clock. It checks the start bit, optional parity and stop bit, then presents each word with a one-cycle done strobe and error flags.

Parameters:
OVERSAMPLING, 8, oversample ticks per bit; even, ≥4; must match baud_generator OVERSAMPLING_RATE
DATA_BITS, 8, data bits per frame (5..9)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
SYNC_STAGES, 2, input synchronizer depth (≥2)

Ports:
sysclk_in  in  1  system clock; all state updates on its rising edge
nrst_in  in  1  asynchronous active-low reset
divclk_in  in  1  oversampling clock from baud_generator; its rising edge, detected in the sysclk domain, is one tick
rx_serial_in  in  1  asynchronous serial line; idles high
rx_data_out  out  DATA_BITS  last received word; held until the next done
rx_done_out  out  1  one sysclk pulse per completed frame
rx_busy_out  out  1  high in any state except IDLE
rx_frame_err_out  out  1  valid with rx_done_out; stop bit sampled low
rx_parity_err_out  out  1  valid with rx_done_out; parity mismatch (always 0 when PARITY_MODE = 0)

Behaviour:
- Reset:
  - Reset is asynchronous, active low: nrst_in low forces every output to 0 and the FSM to IDLE immediately.
  - Synchronizer flops reset to 1 (idle line), so reset release does not look like a start bit.
- Input path:
  - rx_serial_in passes through SYNC_STAGES flops; the synchronized line is rxs.
  - divclk_in passes through 2 flops plus an edge detect, giving tick, a 1-sysclk pulse.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLING) bits; bit_cnt is $clog2(DATA_BITS) bits. Both are cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling edge on rxs goes to START. The edge is detected per sysclk, not per tick.
  - START: counts ticks. At tick_cnt = OVERSAMPLING/2-1, on the tick:
    - rxs = 0 goes to DATA;
    - rxs = 1 is treated as a glitch, returns to IDLE, and produces no done.
  - DATA:
    - Every OVERSAMPLING ticks (mid-bit), shift rxs into the MSB of the shift register (right shift), so the first received bit ends up in bit 0.
    - After DATA_BITS samples, go to PARITY if PARITY_MODE ≠ 0, else to STOP.
  - PARITY: mid-bit sample. Compute mismatch against XOR of the data, inverted for odd mode.
  - STOP: mid-bit sample.
    - rxs = 1: next sysclk, load rx_data_out, pulse rx_done_out, drive the error flags, go to IDLE.
    - rxs = 0: the same done pulse with rx_frame_err_out = 1, data still loaded, then go to BREAK.
  - BREAK: wait for rxs = 1, then go to IDLE. No further done pulses while the line stays low.
- Latency: rx_done_out rises exactly 1 sysclk after the tick that samples the stop bit.
- Error flags: registered with done and held until the next done.
- Back-to-back frames: IDLE is entered half a bit before the stop bit ends, so a start edge that immediately follows a stop bit is caught.
- Ticks arriving while in IDLE are ignored.
- No reception handshake: if the consumer misses a done, the word is overwritten (no overrun flag).

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a function for the parity bit.
- Sub-module bit_synchronizer (parameter STAGES, reset value 1):
  - instantiated for rx_serial_in with STAGES = SYNC_STAGES;
  - also instantiated for divclk_in with STAGES = 2;
  - edge detect stays in uart_rx.

Test Plan:
- Loopback: uart_tx.tx_serial_out drives uart_rx; baud_generator runs at 100 MHz / 115200 / 8. Send 0xA5, 0x00, 0xFF -> three done pulses; rx_data_out matches each word; both error flags 0.
- 16 back-to-back random words, with data_rdy_in held high on uart_tx -> 16 done pulses; every word matches in order; none dropped.
- Glitch: drive the line low for 2 ticks, then high -> rx_done_out never pulses; rx_busy_out returns to 0 within 4 ticks.
- Framing: send 0x3C with the stop bit forced low and the line held low for 3 bit times -> exactly one done with rx_frame_err_out = 1 and data 0x3C. A following good frame 0x11 is received cleanly.
- Parity with PARITY_MODE = 1:
  - 0x07 with parity bit 1 -> parity_err = 0;
  - 0x07 with parity bit 0 -> parity_err = 1.
- Reset mid-frame: assert nrst_in during bit 4 -> all outputs 0 asynchronously. After release, the next frame 0x5A is received correctly with no spurious done.
